// File: rtl/program_runner.sv
// Interpreter for generated FPGA test programs: executes a loaded program against
// a local memory, with FIFO-buffered input/output channels and a pass/fail verdict.
module program_runner #(
  parameter int WIDTH       = 12,
  parameter int LOCAL_DEPTH = 16,
  parameter int PROG_DEPTH  = 32,
  parameter int IN_DEPTH    = 8,
  parameter int OUT_DEPTH   = 8,
  parameter int MAX_STEPS   = 1000,
  localparam int A  = $clog2(LOCAL_DEPTH),
  localparam int P  = $clog2(PROG_DEPTH),
  localparam int IW = 4 + A + 2 * (WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [P-1:0]     load_addr,
  input  logic [IW-1:0]    load_data,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             finished,
  output logic             success,
  output logic [1:0]       error,
  output logic [P-1:0]     ip,
  output logic [31:0]      steps
);
  localparam int IA = $clog2(IN_DEPTH);
  localparam int OA = $clog2(OUT_DEPTH);
  localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MOV = 4'd3, OP_OUT = 4'd4,
                         OP_IN = 4'd5, OP_JEQ = 4'd6, OP_JMP = 4'd7, OP_ASSERT = 4'd8,
                         OP_HALT = 4'd9;
  localparam logic [P-1:0]  IP_ONE     = 1;
  localparam logic [P-1:0]  IP_LAST    = '1;
  localparam logic [31:0]   STEP_LIMIT = MAX_STEPS[31:0];
  localparam logic [IA-1:0] IN_PONE    = 1;
  localparam logic [IA:0]   IN_CONE    = 1;
  localparam logic [IA:0]   IN_FULL    = IN_DEPTH[IA:0];
  localparam logic [OA-1:0] OUT_PONE   = 1;
  localparam logic [OA:0]   OUT_CONE   = 1;
  localparam logic [OA:0]   OUT_FULL   = OUT_DEPTH[OA:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [P-1:0]      ip_q, ip_d;
  logic [31:0]       steps_q, steps_d;
  logic [1:0]        error_q, error_d;
  logic              assert_fail_q, assert_fail_d;
  logic [IW-1:0]     prog_q [PROG_DEPTH];
  logic [WIDTH-1:0]  mem_q [LOCAL_DEPTH];
  logic [WIDTH-1:0]  in_buf_q [IN_DEPTH];
  logic [WIDTH-1:0]  out_buf_q [OUT_DEPTH];
  logic [IA-1:0]     in_wp_q, in_rp_q;
  logic [IA:0]       in_cnt_q;
  logic [OA-1:0]     out_wp_q, out_rp_q;
  logic [OA:0]       out_cnt_q;

  logic [IW-1:0]     instr;
  logic [3:0]        op;
  logic [A-1:0]      tgt;
  logic              a_imm, b_imm;
  logic [WIDTH-1:0]  f_a, f_b, a_val, b_val, tgt_val;
  logic              in_full, in_empty, out_full, out_empty;
  logic              in_push, in_pop, out_push, out_pop;
  logic              stall, retire, start_go, jump, mem_we;
  logic [WIDTH-1:0]  mem_wdata;

  assign instr   = prog_q[ip_q];
  assign op      = instr[IW-1 -: 4];
  assign tgt     = instr[IW-5 -: A];
  assign a_imm   = instr[2*WIDTH+1];
  assign f_a     = instr[2*WIDTH:WIDTH+1];
  assign b_imm   = instr[WIDTH];
  assign f_b     = instr[WIDTH-1:0];
  assign a_val   = a_imm ? f_a : mem_q[f_a[A-1:0]];
  assign b_val   = b_imm ? f_b : mem_q[f_b[A-1:0]];
  assign tgt_val = mem_q[tgt];

  assign in_full   = (in_cnt_q == IN_FULL);
  assign in_empty  = (in_cnt_q == '0);
  assign out_full  = (out_cnt_q == OUT_FULL);
  assign out_empty = (out_cnt_q == '0);
  assign in_push   = in_valid && !in_full;
  assign out_pop   = !out_empty && out_ready;
  assign in_pop    = retire && (op == OP_IN);
  assign out_push  = retire && (op == OP_OUT);
  assign stall     = ((op == OP_OUT) && out_full) || ((op == OP_IN) && in_empty);
  assign jump      = (op == OP_JMP) || ((op == OP_JEQ) && (tgt_val == a_val));

  always_comb begin
    state_d       = state_q;
    ip_d          = ip_q;
    steps_d       = steps_q;
    error_d       = error_q;
    assert_fail_d = assert_fail_q;
    retire        = 1'b0;
    start_go      = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_go      = 1'b1;
          state_d       = S_RUN;
          ip_d          = '0;
          steps_d       = '0;
          error_d       = 2'd0;
          assert_fail_d = 1'b0;
        end
      end
      default: begin
        if (op > OP_HALT) begin
          error_d = 2'd2;
          state_d = S_DONE;
        end else if (!stall) begin
          retire  = 1'b1;
          steps_d = steps_q + 32'd1;
          case (op)
            OP_ADD: begin mem_we = 1'b1; mem_wdata = a_val + b_val; end
            OP_SUB: begin mem_we = 1'b1; mem_wdata = a_val - b_val; end
            OP_MOV: begin mem_we = 1'b1; mem_wdata = a_val; end
            OP_IN:  begin mem_we = 1'b1; mem_wdata = in_buf_q[in_rp_q]; end
            OP_ASSERT: if (a_val != b_val) assert_fail_d = 1'b1;
            default: ;
          endcase
          if (op == OP_HALT) begin
            state_d = S_DONE;
          end else if (!jump && (ip_q == IP_LAST)) begin
            error_d = 2'd3;
            state_d = S_DONE;
          end else begin
            ip_d = jump ? f_b[P-1:0] : ip_q + IP_ONE;
            if (steps_d == STEP_LIMIT) begin
              error_d = 2'd1;
              state_d = S_DONE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ip_q          <= '0;
      steps_q       <= '0;
      error_q       <= 2'd0;
      assert_fail_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ip_q          <= ip_d;
      steps_q       <= steps_d;
      error_q       <= error_d;
      assert_fail_q <= assert_fail_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start_go) begin
      for (int i = 0; i < LOCAL_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[tgt] <= mem_wdata;
    end
  end

  // Program store is deliberately not reset so a loaded program survives reset.
  always_ff @(posedge clock) begin
    if (load && (state_q != S_RUN)) prog_q[load_addr] <= load_data;
    if (in_push) in_buf_q[in_wp_q] <= in_data;
    if (out_push) out_buf_q[out_wp_q] <= a_val;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_wp_q  <= '0;
      in_rp_q  <= '0;
      in_cnt_q <= '0;
    end else begin
      if (in_push) in_wp_q <= in_wp_q + IN_PONE;
      if (in_pop)  in_rp_q <= in_rp_q + IN_PONE;
      if (in_push && !in_pop)      in_cnt_q <= in_cnt_q + IN_CONE;
      else if (!in_push && in_pop) in_cnt_q <= in_cnt_q - IN_CONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start_go) begin
      out_wp_q  <= '0;
      out_rp_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (out_push) out_wp_q <= out_wp_q + OUT_PONE;
      if (out_pop)  out_rp_q <= out_rp_q + OUT_PONE;
      if (out_push && !out_pop)      out_cnt_q <= out_cnt_q + OUT_CONE;
      else if (!out_push && out_pop) out_cnt_q <= out_cnt_q - OUT_CONE;
    end
  end

  assign in_ready  = !in_full;
  assign out_valid = !out_empty;
  assign out_data  = out_buf_q[out_rp_q];
  assign finished  = (state_q == S_DONE);
  assign success   = finished && (error_q == 2'd0) && !assert_fail_q;
  assign error     = error_q;
  assign ip        = ip_q;
  assign steps     = steps_q;
endmodule

// File: tb/tb_program_runner.sv
// Directed bench for program_runner: small hand-assembled programs with
// hand-computed verdicts, outputs and step counts.
module tb_program_runner;
  logic        clock = 1'b0;
  logic        reset, load, start, start_to, in_valid, out_ready;
  logic [4:0]  load_addr;
  logic [33:0] load_data;
  logic [11:0] in_data;
  logic        in_ready, out_valid, finished, success;
  logic [11:0] out_data;
  logic [1:0]  error;
  logic [4:0]  ip;
  logic [31:0] steps;
  logic        in_ready_to, out_valid_to, finished_to, success_to;
  logic [11:0] out_data_to;
  logic [1:0]  error_to;
  logic [4:0]  ip_to;
  logic [31:0] steps_to;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  program_runner #(.MAX_STEPS(20000)) u_dut (
    .clock(clock), .reset(reset), .load(load), .load_addr(load_addr), .load_data(load_data),
    .start(start), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .finished(finished), .success(success), .error(error), .ip(ip), .steps(steps));

  program_runner #(.MAX_STEPS(10)) u_dut_to (
    .clock(clock), .reset(reset), .load(load), .load_addr(load_addr), .load_data(load_data),
    .start(start_to), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_to),
    .out_valid(out_valid_to), .out_data(out_data_to), .out_ready(out_ready),
    .finished(finished_to), .success(success_to), .error(error_to), .ip(ip_to), .steps(steps_to));

  function automatic logic [33:0] enc(input logic [3:0] op, input logic [3:0] tgt,
                                      input logic ai, input logic [11:0] a,
                                      input logic bi, input logic [11:0] b);
    return {op, tgt, ai, a, bi, b};
  endfunction

  task automatic load_word(input int addr, input logic [33:0] w);
    @(negedge clock);
    load = 1'b1; load_addr = addr[4:0]; load_data = w;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clock); out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (finished) begin ok = 1'b1; break; end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++; if (finished !== 1'b0) begin errors++; $display("FAIL reset_finished got %0b want 0", finished); end
    checks++; if (success !== 1'b0) begin errors++; $display("FAIL reset_success got %0b want 0", success); end
    checks++; if (error !== 2'd0) begin errors++; $display("FAIL reset_error got %0d want 0", error); end
    checks++; if (steps !== 32'd0 || ip !== 5'd0) begin errors++; $display("FAIL reset_steps_ip got %0d/%0d want 0/0", steps, ip); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_fifo got ov=%0b ir=%0b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_add();
    bit ok;
    load_word(0, enc(4'd3, 4'd0, 1'b1, 12'd3, 1'b0, 12'd0));
    load_word(1, enc(4'd1, 4'd0, 1'b0, 12'd0, 1'b1, 12'd2));
    load_word(2, enc(4'd4, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    load_word(3, enc(4'd8, 4'd0, 1'b0, 12'd0, 1'b1, 12'd5));
    load_word(4, enc(4'd9, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    pulse_start();
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_done got timeout want finished"); end
    checks++; if (success !== 1'b1 || error !== 2'd0) begin errors++; $display("FAIL add_verdict got s=%0b e=%0d want 1/0", success, error); end
    checks++; if (steps !== 32'd5) begin errors++; $display("FAIL add_steps got %0d want 5", steps); end
    checks++; if (out_valid !== 1'b1 || out_data !== 12'd5) begin errors++; $display("FAIL add_out got v=%0b d=%0d want 1/5", out_valid, out_data); end
    pop_one();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_pop got %0b want 0", out_valid); end
  endtask

  task automatic test_echo_stall();
    bit ok;
    load_word(0, enc(4'd5, 4'd1, 1'b0, 12'd0, 1'b0, 12'd0));
    load_word(1, enc(4'd4, 4'd0, 1'b0, 12'd1, 1'b0, 12'd0));
    load_word(2, enc(4'd9, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    pulse_start();
    repeat (3) @(negedge clock);
    checks++; if (steps !== 32'd0 || ip !== 5'd0 || finished !== 1'b0) begin errors++; $display("FAIL echo_stall got st=%0d ip=%0d f=%0b want 0/0/0", steps, ip, finished); end
    in_valid = 1'b1; in_data = 12'hABC;
    @(negedge clock);
    in_valid = 1'b0;
    wait_done(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL echo_done got timeout want finished"); end
    checks++; if (out_data !== 12'hABC || out_valid !== 1'b1) begin errors++; $display("FAIL echo_out got v=%0b d=%0h want 1/abc", out_valid, out_data); end
    checks++; if (success !== 1'b1 || steps !== 32'd3) begin errors++; $display("FAIL echo_verdict got s=%0b st=%0d want 1/3", success, steps); end
    pop_one();
  endtask

  task automatic test_loop_wrap();
    bit ok;
    load_word(0, enc(4'd3, 4'd0, 1'b1, 12'd0, 1'b0, 12'd0));
    load_word(1, enc(4'd1, 4'd0, 1'b0, 12'd0, 1'b1, 12'd1));
    load_word(2, enc(4'd6, 4'd0, 1'b1, 12'd4095, 1'b0, 12'd4));
    load_word(3, enc(4'd7, 4'd0, 1'b0, 12'd0, 1'b0, 12'd1));
    load_word(4, enc(4'd4, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    load_word(5, enc(4'd1, 4'd0, 1'b0, 12'd0, 1'b1, 12'd1));
    load_word(6, enc(4'd4, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    load_word(7, enc(4'd9, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    pulse_start();
    wait_done(13000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_done got timeout want finished"); end
    checks++; if (steps !== 32'd12289 || success !== 1'b1) begin errors++; $display("FAIL loop_steps got st=%0d s=%0b want 12289/1", steps, success); end
    checks++; if (out_data !== 12'hFFF) begin errors++; $display("FAIL loop_max got %0h want fff", out_data); end
    pop_one();
    checks++; if (out_valid !== 1'b1 || out_data !== 12'h000) begin errors++; $display("FAIL loop_wrap got v=%0b d=%0h want 1/0", out_valid, out_data); end
    pop_one();
  endtask

  task automatic test_timeout();
    bit ok;
    load_word(0, enc(4'd7, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    @(negedge clock); start_to = 1'b1;
    @(negedge clock); start_to = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (finished_to) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (!ok) begin errors++; $display("FAIL timeout_done got timeout want finished"); end
    checks++; if (error_to !== 2'd1 || success_to !== 1'b0) begin errors++; $display("FAIL timeout_err got e=%0d s=%0b want 1/0", error_to, success_to); end
    checks++; if (steps_to !== 32'd10) begin errors++; $display("FAIL timeout_steps got %0d want 10", steps_to); end
  endtask

  task automatic test_errors();
    bit ok;
    load_word(0, enc(4'd12, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    pulse_start();
    wait_done(20, ok);
    checks++; if (!ok || error !== 2'd2 || success !== 1'b0) begin errors++; $display("FAIL illegal_op got ok=%0b e=%0d s=%0b want 1/2/0", ok, error, success); end
    for (int i = 0; i < 32; i++) load_word(i, 34'd0);
    pulse_start();
    wait_done(60, ok);
    checks++; if (!ok || error !== 2'd3) begin errors++; $display("FAIL ip_overflow got ok=%0b e=%0d want 1/3", ok, error); end
    checks++; if (steps !== 32'd32 || ip !== 5'd31) begin errors++; $display("FAIL overflow_steps got st=%0d ip=%0d want 32/31", steps, ip); end
    load_word(0, enc(4'd8, 4'd0, 1'b1, 12'd1, 1'b1, 12'd2));
    load_word(1, enc(4'd9, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    pulse_start();
    wait_done(20, ok);
    checks++; if (!ok || success !== 1'b0 || error !== 2'd0) begin errors++; $display("FAIL assert_fail got ok=%0b s=%0b e=%0d want 1/0/0", ok, success, error); end
    checks++; if (steps !== 32'd2) begin errors++; $display("FAIL assert_steps got %0d want 2", steps); end
  endtask

  task automatic test_backpressure_reset();
    for (int i = 0; i < 9; i++) load_word(i, enc(4'd4, 4'd0, 1'b1, 12'(i + 1), 1'b0, 12'd0));
    load_word(9, enc(4'd9, 4'd0, 1'b0, 12'd0, 1'b0, 12'd0));
    out_ready = 1'b0;
    pulse_start();
    repeat (20) @(negedge clock);
    checks++; if (finished !== 1'b0 || ip !== 5'd8 || steps !== 32'd8) begin errors++; $display("FAIL bp_stall got f=%0b ip=%0d st=%0d want 0/8/8", finished, ip, steps); end
    checks++; if (out_valid !== 1'b1 || out_data !== 12'd1) begin errors++; $display("FAIL bp_head got v=%0b d=%0d want 1/1", out_valid, out_data); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || finished !== 1'b0) begin errors++; $display("FAIL bp_reset got v=%0b f=%0b want 0/0", out_valid, finished); end
    repeat (3) @(negedge clock);
    checks++; if (steps !== 32'd0 || ip !== 5'd0) begin errors++; $display("FAIL bp_idle got st=%0d ip=%0d want 0/0", steps, ip); end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; start_to = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_echo_stall();
    test_loop_wrap();
    test_timeout();
    test_errors();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
